i2c_slave_regif: RTL and testbench

I2C_SLAVE_REGIF -- requirements
Module: i2c_slave_regif

---
 rtl/i2c_pkg.sv | 12 +
 rtl/i2c_sig_filter.sv | 28 ++
 rtl/i2c_slave_regif.sv | 144 ++++++++++++++
 tb/tb_i2c_slave_regif.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared FSM state encoding, bus bit constants and address match helper for the I2C register slave
package i2c_pkg;
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR, WR_ACK, RD, RD_ACK, IGNORE
  } i2c_state_e;
  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;
  // General call (address 0) never matches, whatever the configured address
  function automatic logic addr_hit(input logic [7:0] b, input logic [6:0] a);
    return (b[7:1] == a) && (b[7:1] != 7'd0);
  endfunction
endpackage

// File: rtl/i2c_sig_filter.sv
// i2c_sig_filter: 2-FF synchronizer followed by a level filter that needs filt_len equal samples to change
module i2c_sig_filter #(
  parameter int filt_len = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic in_i,
  output logic out_o
);
  logic [1:0] sync_q;
  logic [2:0] cnt_q;
  logic       out_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
      cnt_q  <= 3'd0;
      out_q  <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], in_i};
      if (sync_q[1] == out_q) cnt_q <= 3'd0;
      else if (cnt_q == 3'(filt_len - 1)) begin
        out_q <= sync_q[1];
        cnt_q <= 3'd0;
      end else cnt_q <= cnt_q + 3'd1;
    end
  end
  assign out_o = out_q;
endmodule

// File: rtl/i2c_slave_regif.sv
// i2c_slave_regif: I2C target giving a master pointer-based access to an external 8-bit register file
module i2c_slave_regif
  import i2c_pkg::*;
#(
  parameter logic [6:0] slave_addr       = 7'h50,
  parameter int         filt_len         = 3,
  parameter int         simulation_delay = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_t,
  output logic       sda_o,
  output logic [7:0] reg_ptr,
  input  logic [7:0] reg_rdata,
  output logic       reg_wen,
  output logic [7:0] reg_waddr,
  output logic [7:0] reg_wdata,
  output logic       busy
);
  i2c_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d, ptr_q, ptr_d, waddr_q, waddr_d, wdata_q, wdata_d;
  logic       sda_t_q, sda_t_d, wen_q, wen_d, busy_q, busy_d;
  logic       scl_f, sda_f, scl_p_q, sda_p_q;
  logic       scl_rise, scl_fall, start, stop;
  logic       unused_sim_dly;
  assign unused_sim_dly = |simulation_delay;
  i2c_sig_filter #(.filt_len(filt_len)) u_scl (.clk(clk), .rst(rst), .in_i(scl_i), .out_o(scl_f));
  i2c_sig_filter #(.filt_len(filt_len)) u_sda (.clk(clk), .rst(rst), .in_i(sda_i), .out_o(sda_f));
  assign scl_rise = scl_f & ~scl_p_q;
  assign scl_fall = ~scl_f & scl_p_q;
  assign start    = scl_f & scl_p_q & sda_p_q & ~sda_f;
  assign stop     = scl_f & scl_p_q & ~sda_p_q & sda_f;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      sh_q    <= 8'd0;
      ptr_q   <= 8'd0;
      waddr_q <= 8'd0;
      wdata_q <= 8'd0;
      sda_t_q <= 1'b1;
      wen_q   <= 1'b0;
      busy_q  <= 1'b0;
      scl_p_q <= 1'b1;
      sda_p_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      ptr_q   <= ptr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      sda_t_q <= sda_t_d;
      wen_q   <= wen_d;
      busy_q  <= busy_d;
      scl_p_q <= scl_f;
      sda_p_q <= sda_f;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    ptr_d   = wen_q ? ptr_q + 8'd1 : ptr_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    sda_t_d = sda_t_q;
    wen_d   = 1'b0;
    busy_d  = busy_q;
    if (stop) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      sda_t_d = 1'b1;
    end else if (start) begin
      state_d = ADDR;
      busy_d  = 1'b1;
      sda_t_d = 1'b1;
      cnt_d   = 4'd0;
    end else if (scl_rise) begin
      if (state_q inside {ADDR, PTR, WR, RD}) cnt_d = cnt_q + 4'd1;
      if (state_q inside {ADDR, PTR, WR}) sh_d = {sh_q[6:0], sda_f};
      // The pointer advances past every byte read; the master's ACK/NACK only decides whether to continue
      if (state_q == RD_ACK) begin
        ptr_d   = ptr_q + 8'd1;
        state_d = (sda_f == NACK) ? IGNORE : RD_ACK;
      end
    end else if (scl_fall) begin
      case (state_q)
        ADDR: if (cnt_q == 4'd8) begin
          cnt_d   = 4'd0;
          state_d = addr_hit(sh_q, slave_addr) ? ADDR_ACK : IGNORE;
          sda_t_d = addr_hit(sh_q, slave_addr) ? ACK : 1'b1;
        end
        PTR: if (cnt_q == 4'd8) begin
          cnt_d   = 4'd0;
          ptr_d   = sh_q;
          state_d = PTR_ACK;
          sda_t_d = ACK;
        end
        WR: if (cnt_q == 4'd8) begin
          cnt_d   = 4'd0;
          wen_d   = 1'b1;
          waddr_d = ptr_q;
          wdata_d = sh_q;
          state_d = WR_ACK;
          sda_t_d = ACK;
        end
        RD: if (cnt_q == 4'd8) begin
          cnt_d   = 4'd0;
          state_d = RD_ACK;
          sda_t_d = 1'b1;
        end else begin
          sda_t_d = sh_q[6];
          sh_d    = {sh_q[6:0], 1'b0};
        end
        ADDR_ACK: begin
          state_d = sh_q[0] ? RD : PTR;
          sh_d    = sh_q[0] ? reg_rdata : sh_q;
          sda_t_d = sh_q[0] ? reg_rdata[7] : 1'b1;
        end
        RD_ACK: begin
          state_d = RD;
          sh_d    = reg_rdata;
          sda_t_d = reg_rdata[7];
        end
        PTR_ACK, WR_ACK: begin
          state_d = WR;
          sda_t_d = 1'b1;
        end
        default: ;
      endcase
    end
  end
  assign sda_t     = sda_t_q;
  assign sda_o     = 1'b0;
  assign reg_ptr   = ptr_q;
  assign reg_wen   = wen_q;
  assign reg_waddr = waddr_q;
  assign reg_wdata = wdata_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_i2c_slave_regif.sv
// tb_i2c_slave_regif: directed I2C master transactions against i2c_slave_regif with a behavioural register file
module tb_i2c_slave_regif;
  localparam int Q = 10;
  logic clk = 1'b0, rst = 1'b1, scl = 1'b1, m_sda = 1'b1;
  logic sda_t, sda_o, reg_wen, busy;
  logic [7:0] reg_ptr, reg_rdata, reg_waddr, reg_wdata;
  logic [7:0] mem [256];
  logic [15:0] wlog [$];
  logic wen_prev = 1'b0, wen_double = 1'b0, sda_driven = 1'b0;
  int n_chk = 0, n_fail = 0;
  wire sda_bus = m_sda & (sda_t | sda_o);
  always #5 clk = ~clk;
  assign reg_rdata = mem[reg_ptr];
  i2c_slave_regif dut (
    .clk(clk), .rst(rst), .scl_i(scl), .sda_i(sda_bus), .sda_t(sda_t), .sda_o(sda_o),
    .reg_ptr(reg_ptr), .reg_rdata(reg_rdata), .reg_wen(reg_wen), .reg_waddr(reg_waddr),
    .reg_wdata(reg_wdata), .busy(busy)
  );
  always @(negedge clk) begin
    if (reg_wen) begin
      wlog.push_back({reg_waddr, reg_wdata});
      mem[reg_waddr] = reg_wdata;
    end
    if (reg_wen && wen_prev) wen_double = 1'b1;
    if (!sda_t) sda_driven = 1'b1;
    wen_prev = reg_wen;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic i2c_start();
    m_sda = 1'b1; wait_clk(Q);
    scl = 1'b1;   wait_clk(Q);
    m_sda = 1'b0; wait_clk(Q);
    scl = 1'b0;   wait_clk(Q);
  endtask
  task automatic i2c_stop();
    m_sda = 1'b0; wait_clk(Q);
    scl = 1'b1;   wait_clk(Q);
    m_sda = 1'b1; wait_clk(Q);
  endtask
  task automatic write_bit(input logic b, input logic glitch);
    m_sda = b; wait_clk(Q);
    scl = 1'b1; wait_clk(Q);
    if (glitch) begin
      scl = 1'b0; wait_clk(2);
      scl = 1'b1;
    end
    wait_clk(Q);
    scl = 1'b0; wait_clk(Q);
  endtask
  task automatic read_bit(output logic b);
    m_sda = 1'b1; wait_clk(Q);
    scl = 1'b1;   wait_clk(Q);
    b = sda_bus;  wait_clk(Q);
    scl = 1'b0;   wait_clk(Q);
  endtask
  task automatic write_byte(input logic [7:0] d, input int gbit, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i], i == gbit);
    read_bit(ack);
  endtask
  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(mack, 1'b0);
  endtask
  task automatic clear_mon();
    wlog.delete();
    wen_double = 1'b0;
    sda_driven = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; wait_clk(5);
    rst = 1'b0; wait_clk(20);
    n_chk++; if (sda_t !== 1'b1) begin n_fail++; $display("FAIL reset_sda_t: got %b want 1", sda_t); end
    n_chk++; if (sda_o !== 1'b0) begin n_fail++; $display("FAIL reset_sda_o: got %b want 0", sda_o); end
    n_chk++; if (reg_ptr !== 8'h00) begin n_fail++; $display("FAIL reset_ptr: got %h want 00", reg_ptr); end
    n_chk++; if (reg_wen !== 1'b0) begin n_fail++; $display("FAIL reset_wen: got %b want 0", reg_wen); end
    n_chk++; if ({reg_waddr, reg_wdata} !== 16'h0000) begin n_fail++; $display("FAIL reset_wbus: got %h%h want 0000", reg_waddr, reg_wdata); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_write();
    logic a0, a1, a2, a3;
    logic [15:0] w0, w1;
    clear_mon();
    i2c_start();
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL write_busy: got %b want 1", busy); end
    write_byte(8'hA0, -1, a0);
    write_byte(8'h10, -1, a1);
    write_byte(8'h55, -1, a2);
    write_byte(8'hAA, -1, a3);
    i2c_stop();
    w0 = wlog.size() > 0 ? wlog[0] : 16'hxxxx;
    w1 = wlog.size() > 1 ? wlog[1] : 16'hxxxx;
    n_chk++; if ({a0, a1, a2, a3} !== 4'b0000) begin n_fail++; $display("FAIL write_acks: got %b want 0000", {a0, a1, a2, a3}); end
    n_chk++; if (wlog.size() != 2) begin n_fail++; $display("FAIL write_count: got %0d want 2", wlog.size()); end
    n_chk++; if (w0 !== 16'h1055) begin n_fail++; $display("FAIL write_first: got %h want 1055", w0); end
    n_chk++; if (w1 !== 16'h11AA) begin n_fail++; $display("FAIL write_second: got %h want 11aa", w1); end
    n_chk++; if (reg_ptr !== 8'h12) begin n_fail++; $display("FAIL write_ptr: got %h want 12", reg_ptr); end
    n_chk++; if (wen_double !== 1'b0) begin n_fail++; $display("FAIL write_wen_width: got %b want 0", wen_double); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL write_busy_stop: got %b want 0", busy); end
  endtask

  task automatic test_read();
    logic a0, a1, a2;
    logic [7:0] d0, d1;
    mem[8'h20] = 8'h3C;
    mem[8'h21] = 8'hC5;
    clear_mon();
    i2c_start();
    write_byte(8'hA0, -1, a0);
    write_byte(8'h20, -1, a1);
    i2c_start();
    write_byte(8'hA1, -1, a2);
    read_byte(1'b0, d0);
    read_byte(1'b1, d1);
    n_chk++; if (sda_t !== 1'b1) begin n_fail++; $display("FAIL read_release: got %b want 1", sda_t); end
    i2c_stop();
    n_chk++; if ({a0, a1, a2} !== 3'b000) begin n_fail++; $display("FAIL read_acks: got %b want 000", {a0, a1, a2}); end
    n_chk++; if (d0 !== 8'h3C) begin n_fail++; $display("FAIL read_byte0: got %h want 3c", d0); end
    n_chk++; if (d1 !== 8'hC5) begin n_fail++; $display("FAIL read_byte1: got %h want c5", d1); end
    n_chk++; if (reg_ptr !== 8'h22) begin n_fail++; $display("FAIL read_ptr: got %h want 22", reg_ptr); end
    n_chk++; if (wlog.size() != 0) begin n_fail++; $display("FAIL read_no_write: got %0d want 0", wlog.size()); end
  endtask

  task automatic test_wrong_addr();
    logic a0, a1, g0;
    clear_mon();
    i2c_start();
    write_byte(8'h84, -1, a0);
    write_byte(8'h12, -1, a1);
    i2c_start();
    write_byte(8'h00, -1, g0);
    i2c_stop();
    n_chk++; if ({a0, a1} !== 2'b11) begin n_fail++; $display("FAIL wrong_addr_nack: got %b want 11", {a0, a1}); end
    n_chk++; if (g0 !== 1'b1) begin n_fail++; $display("FAIL general_call_nack: got %b want 1", g0); end
    n_chk++; if (sda_driven !== 1'b0) begin n_fail++; $display("FAIL wrong_addr_sda: got driven=%b want 0", sda_driven); end
    n_chk++; if (wlog.size() != 0) begin n_fail++; $display("FAIL wrong_addr_write: got %0d want 0", wlog.size()); end
  endtask

  task automatic test_ptr_wrap();
    logic a0, a1, a2, a3;
    logic [15:0] w0, w1;
    clear_mon();
    i2c_start();
    write_byte(8'hA0, -1, a0);
    write_byte(8'hFF, -1, a1);
    write_byte(8'h01, -1, a2);
    write_byte(8'h02, -1, a3);
    i2c_stop();
    w0 = wlog.size() > 0 ? wlog[0] : 16'hxxxx;
    w1 = wlog.size() > 1 ? wlog[1] : 16'hxxxx;
    n_chk++; if ({a0, a1, a2, a3} !== 4'b0000) begin n_fail++; $display("FAIL wrap_acks: got %b want 0000", {a0, a1, a2, a3}); end
    n_chk++; if (w0 !== 16'hFF01) begin n_fail++; $display("FAIL wrap_first: got %h want ff01", w0); end
    n_chk++; if (w1 !== 16'h0002) begin n_fail++; $display("FAIL wrap_second: got %h want 0002", w1); end
    n_chk++; if (reg_ptr !== 8'h01) begin n_fail++; $display("FAIL wrap_ptr: got %h want 01", reg_ptr); end
  endtask

  task automatic test_glitch();
    logic a0, a1, a2, a3;
    logic [15:0] w0, w1;
    clear_mon();
    i2c_start();
    write_byte(8'hA0, -1, a0);
    write_byte(8'h30, -1, a1);
    write_byte(8'h96, 3, a2);
    write_byte(8'h69, 5, a3);
    i2c_stop();
    w0 = wlog.size() > 0 ? wlog[0] : 16'hxxxx;
    w1 = wlog.size() > 1 ? wlog[1] : 16'hxxxx;
    n_chk++; if ({a0, a1, a2, a3} !== 4'b0000) begin n_fail++; $display("FAIL glitch_acks: got %b want 0000", {a0, a1, a2, a3}); end
    n_chk++; if (w0 !== 16'h3096) begin n_fail++; $display("FAIL glitch_first: got %h want 3096", w0); end
    n_chk++; if (w1 !== 16'h3169) begin n_fail++; $display("FAIL glitch_second: got %h want 3169", w1); end
  endtask

  task automatic test_rst_in_ack();
    logic [7:0] a = 8'hA0;
    logic ack;
    clear_mon();
    i2c_start();
    for (int i = 7; i >= 0; i--) write_bit(a[i], 1'b0);
    m_sda = 1'b1; wait_clk(Q);
    n_chk++; if (sda_t !== 1'b0) begin n_fail++; $display("FAIL rst_ack_driven: got %b want 0", sda_t); end
    rst = 1'b1; wait_clk(1);
    n_chk++; if (sda_t !== 1'b1) begin n_fail++; $display("FAIL rst_ack_release: got %b want 1", sda_t); end
    n_chk++; if (reg_ptr !== 8'h00) begin n_fail++; $display("FAIL rst_ack_ptr: got %h want 00", reg_ptr); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_ack_busy: got %b want 0", busy); end
    rst = 1'b0;
    sda_driven = 1'b0;
    wait_clk(Q);
    scl = 1'b1; wait_clk(2 * Q);
    scl = 1'b0; wait_clk(Q);
    write_byte(8'hA0, -1, ack);
    n_chk++; if (ack !== 1'b1) begin n_fail++; $display("FAIL rst_ignore_nack: got %b want 1", ack); end
    n_chk++; if (sda_driven !== 1'b0) begin n_fail++; $display("FAIL rst_ignore_sda: got driven=%b want 0", sda_driven); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_ignore_busy: got %b want 0", busy); end
    i2c_stop();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
    test_reset();
    test_write();
    test_read();
    test_wrong_addr();
    test_ptr_wrap();
    test_glitch();
    test_rst_in_ack();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
